// File: rtl/pong_pkg.sv
// Shared Pong playfield types and defaults for the power-up spawn scheduler.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } sched_state_e;

  localparam int PRESCALER_DEFAULT = 24999999;
  localparam int CNT_W_DEFAULT     = 4;

endpackage

// File: rtl/sec_countdown.sv
// Seconds countdown: a clk prescaler producing one-second ticks that step a
// loadable down-counter; expired flags an empty counter not being reloaded.
module sec_countdown #(
  parameter int CNT_W     = pong_pkg::CNT_W_DEFAULT,
  parameter int PRESCALER = pong_pkg::PRESCALER_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);

  localparam int PS_W = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             tick;

  assign tick    = (presc_q == PS_W'(PRESCALER));
  assign expired = (rem_q == '0) && !load;

  // The prescaler only advances while seconds remain, so it never overflows.
  always_comb begin
    presc_d = presc_q;
    rem_d   = rem_q;
    if (clear) begin
      presc_d = '0;
      rem_d   = '0;
    end else if (load) begin
      presc_d = '0;
      rem_d   = value;
    end else if (rem_q != '0) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      rem_q   <= '0;
    end else begin
      presc_q <= presc_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: rtl/powerup_spawn_scheduler.sv
// Round-robin scheduler sharing one seconds countdown between N_REQ power-up
// items; emits a one-cycle spawn pulse to the owner when its delay expires.
module powerup_spawn_scheduler
  import pong_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int PRESCALER = PRESCALER_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [N_REQ-1:0]       eaten,
  input  logic [N_REQ*CNT_W-1:0] delay_sec,
  output logic [N_REQ-1:0]       spawn,
  output logic                   busy,
  output logic [ID_W-1:0]        active_id,
  output logic [N_REQ-1:0]       pending
);

  sched_state_e     state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] spawn_q, spawn_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             busy_q, busy_d;

  logic             found;
  logic [ID_W-1:0]  win;
  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] owner_mask;
  logic             load;
  logic             expired;
  logic [CNT_W-1:0] load_val;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Scan downward so the lowest offset from rr_q is the one that sticks.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pending_q[wrap_idx(rr_q, k)]) begin
        found = 1'b1;
        win   = wrap_idx(rr_q, k);
      end
    end
  end

  assign load_val = delay_sec[win*CNT_W +: CNT_W];

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    load       = 1'b0;
    grant_oh   = '0;
    owner_mask = '0;
    spawn_d    = '0;
    busy_d     = 1'b0;

    if (state_q == RUN) owner_mask[id_q] = 1'b1;

    case (state_q)
      IDLE: begin
        if (found) begin
          load          = 1'b1;
          grant_oh[win] = 1'b1;
          id_d          = win;
          rr_d          = wrap_idx(win, 1);
          state_d       = RUN;
        end
      end
      RUN:     if (expired) state_d = FIRE;
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q | (eaten & ~owner_mask)) & ~grant_oh;

    // Abort discards any grant decided this cycle along with the queue.
    if (clear) begin
      state_d   = IDLE;
      pending_d = '0;
      load      = 1'b0;
      id_d      = id_q;
      rr_d      = rr_q;
    end

    if (state_d == FIRE) spawn_d[id_d] = 1'b1;
    busy_d = (state_d == RUN) || (state_d == FIRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      spawn_q   <= '0;
      rr_q      <= '0;
      id_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      spawn_q   <= spawn_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
    end
  end

  sec_countdown #(
    .CNT_W     (CNT_W),
    .PRESCALER (PRESCALER)
  ) u_cd (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .clear   (clear),
    .value   (load_val),
    .expired (expired)
  );

  assign spawn     = spawn_q;
  assign busy      = busy_q;
  assign active_id = id_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_powerup_spawn_scheduler.sv
// Scoreboard bench: stimulus queues expected spawn (id, cycle); a negedge
// monitor pops and compares every spawn pulse the scheduler produces.
module tb_powerup_spawn_scheduler;

  localparam int N_REQ     = 4;
  localparam int ID_W      = 2;
  localparam int CNT_W     = 4;
  localparam int PRESCALER = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   clear = 1'b0;
  logic [N_REQ-1:0]       eaten = '0;
  logic [N_REQ*CNT_W-1:0] delay_sec = '0;
  logic [N_REQ-1:0]       spawn;
  logic                   busy;
  logic [ID_W-1:0]        active_id;
  logic [N_REQ-1:0]       pending;

  typedef struct {
    int id;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c0;

  powerup_spawn_scheduler #(
    .N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W), .PRESCALER(PRESCALER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .eaten(eaten),
    .delay_sec(delay_sec), .spawn(spawn), .busy(busy),
    .active_id(active_id), .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spawn !== '0) begin
      checks++;
      if ($countones(spawn) != 1) begin
        errors++;
        $display("FAIL spawn_onehot: got %b at cycle %0d, need exactly one bit", spawn, cyc);
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL spawn_unexpected: got %b at cycle %0d, need no pulse", spawn, cyc);
      end else begin
        mon_e = q.pop_front();
        if (spawn !== 4'(1 << mon_e.id) || cyc != mon_e.at) begin
          errors++;
          $display("FAIL spawn_match: got %b at cycle %0d, need %b at cycle %0d",
                   spawn, cyc, 4'(1 << mon_e.id), mon_e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %0h need %0h (cycle %0d)", name, got, need, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_spawn(input int id, input int at);
    exp_t e;
    e.id = id;
    e.at = at;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    eaten = '0;
    clear = 1'b0;
    q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d spawns outstanding after budget, need 0", name, q.size());
      q.delete();
    end
    tick(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("reset_spawn", spawn, 0);
    chk("reset_busy", busy, 0);
    chk("reset_active", active_id, 0);
    chk("reset_pending", pending, 0);

    // Single request, delay 2: spawn at +11, busy over cycles 2..11
    delay_sec = 16'h0002;
    c0 = cyc;
    eaten = 4'b0001;
    expect_spawn(0, c0 + 11);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      eaten = '0;
      chk("busy_single", busy, (k >= 2 && k <= 11));
      if (k == 1) chk("pending_single", pending, 4'b0001);
      if (k == 5) chk("active_single", active_id, 0);
    end
    wait_drain("drain_single");

    // Zero delay on item 2: spawn at +3
    do_reset();
    delay_sec = 16'h0000;
    c0 = cyc;
    eaten = 4'b0100;
    expect_spawn(2, c0 + 3);
    tick(1);
    eaten = '0;
    wait_drain("drain_zero");

    // Round-robin: all four at once, delay 1 each
    do_reset();
    delay_sec = 16'h1111;
    c0 = cyc;
    eaten = 4'b1111;
    expect_spawn(0, c0 + 7);
    expect_spawn(1, c0 + 14);
    expect_spawn(2, c0 + 21);
    expect_spawn(3, c0 + 28);
    tick(1);
    eaten = '0;
    chk("pending_rr_all", pending, 4'b1111);
    tick(1);
    chk("pending_rr_grant0", pending, 4'b1110);
    chk("active_rr", active_id, 0);
    wait_drain("drain_rr");

    // Pointer wrap: serve 2 then 3, then 0 must beat 3
    do_reset();
    delay_sec = 16'h0001;
    c0 = cyc;
    eaten = 4'b0100;
    expect_spawn(2, c0 + 3);
    tick(1);
    eaten = '0;
    wait_drain("drain_wrap_a");
    c0 = cyc;
    eaten = 4'b1000;
    expect_spawn(3, c0 + 3);
    tick(1);
    eaten = '0;
    wait_drain("drain_wrap_b");
    c0 = cyc;
    eaten = 4'b1001;
    expect_spawn(0, c0 + 7);
    expect_spawn(3, c0 + 10);
    tick(1);
    eaten = '0;
    wait_drain("drain_wrap_c");

    // Owner re-eat during RUN is ignored
    do_reset();
    delay_sec = 16'h0030;
    c0 = cyc;
    eaten = 4'b0010;
    expect_spawn(1, c0 + 15);
    tick(1);
    eaten = '0;
    tick(5);
    eaten = 4'b0010;
    tick(1);
    eaten = '0;
    chk("pending_reeat", pending, 0);
    chk("busy_reeat", busy, 1);
    chk("active_reeat", active_id, 1);
    wait_drain("drain_reeat");
    tick(20);
    chk("pending_reeat_end", pending, 0);

    // Clear during RUN with pending=0110; coincident eaten is dropped
    do_reset();
    delay_sec = 16'h0003;
    c0 = cyc;
    eaten = 4'b0001;
    tick(1);
    eaten = '0;
    tick(3);
    eaten = 4'b0110;
    tick(1);
    eaten = '0;
    chk("pending_pre_clear", pending, 4'b0110);
    chk("busy_pre_clear", busy, 1);
    clear = 1'b1;
    eaten = 4'b1000;
    tick(1);
    clear = 1'b0;
    eaten = '0;
    chk("pending_clear", pending, 0);
    chk("busy_clear", busy, 0);
    tick(20);
    chk("busy_clear_end", busy, 0);
    chk("pending_clear_end", pending, 0);

    // Asynchronous reset mid-RUN
    do_reset();
    delay_sec = 16'h0500;
    c0 = cyc;
    eaten = 4'b0100;
    tick(1);
    eaten = 4'b0001;
    tick(1);
    eaten = '0;
    tick(2);
    chk("pending_pre_rst", pending, 4'b0001);
    chk("busy_pre_rst", busy, 1);
    chk("active_pre_rst", active_id, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_spawn", spawn, 0);
    chk("arst_busy", busy, 0);
    chk("arst_active", active_id, 0);
    chk("arst_pending", pending, 0);
    tick(2);
    rst_n = 1'b1;
    tick(30);
    chk("busy_post_rst", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/powerup_spawn_scheduler.md
Name: powerup_spawn_scheduler

Overview:
- Shares one seconds-based countdown resource between N_REQ power-up items in the Pong playfield.
- Each item raises its `eaten` bit when a paddle or ball consumes it.
- The scheduler queues these requests and grants the shared timer round-robin, loading it with that item's respawn delay.
- When the delay expires it emits a one-cycle spawn pulse to the owning item, then serves the next pending request.

Parameters:
- N_REQ, 4: number of requesting power-up items; must be 2..8.
- ID_W, 2: width of `active_id`; equals ceil(log2(N_REQ)).
- CNT_W, 4: width of each per-item delay field in seconds.
- PRESCALER, 24999999: clk cycles per second minus 1. A one-second tick occurs when the prescaler equals PRESCALER. Benches use 3.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous abort of all pending and running requests.
- eaten, input, N_REQ: per-item request level, sampled every clock.
- delay_sec, input, N_REQ*CNT_W: item i's respawn delay in seconds at bits [i*CNT_W +: CNT_W]. Sampled only at grant.
- spawn, output, N_REQ: one-hot, one-cycle pulse to the item whose delay expired.
- busy, output, 1: high in RUN and FIRE.
- active_id, output, ID_W: index of the current timer owner. Holds its last value when idle.
- pending, output, N_REQ: queued, not-yet-granted requests. Debug/status.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - pending=0, spawn=0, busy=0, active_id=0.
  - Round-robin pointer rr_ptr=0.
  - Prescaler and remaining count = 0.
- Pending update each clock:
  - pending[i] is set when eaten[i]=1, except when i is the current owner in RUN (ignored).
  - pending[i] is cleared when i is granted.
  - Set and grant of the same i in one cycle: grant wins and the bit ends at 0.
  - Re-asserting eaten on an already-pending item has no effect.
- State IDLE:
  - If pending≠0, grant the first set bit searching upward from rr_ptr, modulo N_REQ.
  - At the edge: active_id=winner, remaining=delay_sec[winner], prescaler=0, rr_ptr=winner+1 mod N_REQ, go to RUN.
  - A request whose eaten is first high in the IDLE cycle is not visible to that grant; it is seen next cycle.
- State RUN:
  - Prescaler increments and wraps to 0 after PRESCALER.
  - A tick is prescaler==PRESCALER. On a tick with remaining>0, remaining decrements.
  - When remaining==0 during a RUN cycle, go to FIRE at the next edge.
- State FIRE:
  - spawn[active_id]=1 for exactly this one cycle, then go to IDLE.
  - The next grant therefore starts one cycle later; no back-to-back RUN.
- Latency:
  - With eaten first high in cycle t while idle and nothing else pending, spawn is high in cycle t + D*(PRESCALER+1) + 3, where D = delay_sec.
  - D=0 gives a spawn at t+3.
- clear=1:
  - At the next edge: pending=0, state=IDLE, prescaler=0, remaining=0, spawn=0.
  - A clear coincident with FIRE still lets that cycle's spawn pulse (a registered output) complete; no further pulses follow.
  - clear has priority over eaten in the same cycle; that eaten is dropped.
- eaten[i] in the cycle item i fires sets pending[i] normally, starting a new cycle for that item.
- Width rules:
  - remaining is CNT_W bits and is loaded unsigned.
  - The prescaler is width clog2(PRESCALER+1). No overflow is possible.
- All outputs are registered. spawn is never multi-hot.

Decomposition:
- Shared package (pong_pkg): state enum {IDLE, RUN, FIRE}, PRESCALER_DEFAULT, CNT_W default.
- Sub-module sec_countdown holds the prescaler and down-counter.
  - Inputs: clk, rst_n, load, clear, value[CNT_W-1:0].
  - Output: expired, meaning remaining==0 and not load.
  - It replaces the ad-hoc per-item timer instances.
- The scheduler FSM, pending register and round-robin arbiter stay in the top module.

Test Plan (PRESCALER=3, N_REQ=4):
- Single request: reset, eaten=4'b0001 for cycle 0 only, delay_sec[0]=2 -> spawn=4'b0001 in cycle 11 only; busy high cycles 2–11; active_id=0.
- Zero delay: eaten[2] pulse in cycle 0, delay_sec[2]=0 -> spawn=4'b0100 in cycle 3.
- Round-robin fairness: eaten=4'b1111 in cycle 0, all delays 1 -> spawn order 0,1,2,3. Each spawn is 7 cycles after the previous one; the first is at cycle 7.
- Pointer wrap: after item 3 is granted, eaten=4'b1001 in one cycle -> item 0 is served before item 3.
- Owner re-eat ignored: item 1 running with delay 3, eaten[1] pulses mid-RUN -> exactly one spawn[1]; pending[1] stays 0.
- Abort and async reset:
  - clear during RUN with pending=4'b0110 -> pending=0, idle next cycle, no spawn for 20 cycles.
  - rst_n low mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
